sync_ram_nport: RTL and testbench

Parametrised successor to the team's dual-read synchronous RAM. Provides one masked write port and NUM_RD_P independent registered read ports, with a selectable read-during-write policy, per-port read-valid flags and an optional post-reset clear sweep. Used as the shared storage primitive for line buffers and coefficient tables in the Sobel datapath.

---
 rtl/sync_ram_nport_pkg.sv | 51 +++++
 rtl/sync_ram_nport_if.sv | 37 +++
 rtl/sync_ram_nport_clear_seq.sv | 88 ++++++++
 rtl/sync_ram_nport.sv | 151 +++++++++++++++
 tb/tb_sync_ram_nport.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sync_ram_nport_pkg.sv
// -----------------------------------------------------------------------------
// sync_ram_pkg
// Shared types and helpers for the N-read-port synchronous RAM.
//   rdw_mode_e  : read-during-write policy selector
//   ram_state_e : clear-sweep FSM states
//   lane_merge  : builds a word from an old and a new word under a lane mask
//                 (used both by the array write path and the write-first bypass)
// -----------------------------------------------------------------------------
package sync_ram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

    // Widest word lane_merge can handle; callers zero-extend into this width.
    localparam int unsigned MERGE_W_MAX = 512;
    localparam int unsigned MERGE_IDX_W = 9;

    // Bit i of the result comes from new_word when the mask bit of its lane
    // (lane = i / lane_w) is set, otherwise from old_word.
    function automatic logic [MERGE_W_MAX-1:0] lane_merge(
        input logic [MERGE_W_MAX-1:0] old_word,
        input logic [MERGE_W_MAX-1:0] new_word,
        input logic [MERGE_W_MAX-1:0] mask,
        input int unsigned            lane_w
    );
        logic [MERGE_W_MAX-1:0] merged;
        logic [MERGE_IDX_W-1:0] lane_idx;
        merged = old_word;
        if (lane_w != 0) begin
            for (int i = 0; i < MERGE_W_MAX; i++) begin
                lane_idx = MERGE_IDX_W'(i / lane_w);
                if (mask[lane_idx]) begin
                    merged[i] = new_word[i];
                end else begin
                    merged[i] = old_word[i];
                end
            end
        end else begin
            merged = old_word;
        end
        return merged;
    endfunction

endpackage

// File: rtl/sync_ram_nport_if.sv
// -----------------------------------------------------------------------------
// sync_ram_nport_if
// Access bus of sync_ram_nport: one masked write port, NUM_RD_P packed read
// ports, read data/valid and the clear-sweep busy flag.
//   master : drives write/read requests, receives data_o/valid_o/busy_o
//   slave  : the RAM side
// -----------------------------------------------------------------------------
interface sync_ram_nport_if #(
    parameter int unsigned WIDTH_P  = 32,
    parameter int unsigned DEPTH_P  = 128,
    parameter int unsigned NUM_RD_P = 2,
    parameter int unsigned LANE_W_P = 8
);
    localparam int unsigned ADDR_W  = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int unsigned LANES_W = WIDTH_P / LANE_W_P;

    logic [WIDTH_P-1:0]           data_i;
    logic [ADDR_W-1:0]            wr_addr_i;
    logic                         wr_en_i;
    logic [LANES_W-1:0]           wr_mask_i;
    logic [NUM_RD_P*ADDR_W-1:0]   rd_addr_i;
    logic [NUM_RD_P-1:0]          rd_en_i;
    logic [NUM_RD_P*WIDTH_P-1:0]  data_o;
    logic [NUM_RD_P-1:0]          valid_o;
    logic                         busy_o;

    modport master (
        output data_i, wr_addr_i, wr_en_i, wr_mask_i, rd_addr_i, rd_en_i,
        input  data_o, valid_o, busy_o
    );

    modport slave (
        input  data_i, wr_addr_i, wr_en_i, wr_mask_i, rd_addr_i, rd_en_i,
        output data_o, valid_o, busy_o
    );

endinterface

// File: rtl/sync_ram_nport_clear_seq.sv
// -----------------------------------------------------------------------------
// ram_clear_seq
// Post-reset clear sweep: walks addresses 0..DEPTH_P-1, one per cycle, then
// settles in READY until the next reset.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   busy          : sweep in progress (user accesses must be ignored)
//   clr_we        : write-zero strobe for the array
//   clr_addr      : address being cleared
// -----------------------------------------------------------------------------
module ram_clear_seq
    import sync_ram_pkg::*;
#(
    parameter int unsigned DEPTH_P    = 128,
    parameter int unsigned CLEAR_EN_P = 1,
    parameter int unsigned ADDR_W_P   = 7
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    output logic                busy,
    output logic                clr_we,
    output logic [ADDR_W_P-1:0] clr_addr
);

    localparam ram_state_e          RESET_STATE = (CLEAR_EN_P != 0) ? RAM_CLEAR : RAM_READY;
    localparam logic [ADDR_W_P-1:0] LAST_ADDR   = ADDR_W_P'(DEPTH_P - 1);

    ram_state_e          state_r;
    ram_state_e          state_s;
    logic [ADDR_W_P-1:0] cnt_r;
    logic [ADDR_W_P-1:0] cnt_s;

    // State and sweep-address registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= RESET_STATE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: leave CLEAR on the edge that clears the last word
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            RAM_CLEAR: begin
                cnt_s = cnt_r + ADDR_W_P'(1'b1);
                if (cnt_r == LAST_ADDR) begin
                    state_s = RAM_READY;
                end else begin
                    state_s = RAM_CLEAR;
                end
            end
            RAM_READY: begin
                state_s = RAM_READY;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = RAM_READY;
                cnt_s   = cnt_r;
            end
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_r;
        case (state_r)
            RAM_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            RAM_READY: begin
                busy   = 1'b0;
                clr_we = 1'b0;
            end
            default: begin
                busy   = 1'b0;
                clr_we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sync_ram_nport.sv
// -----------------------------------------------------------------------------
// sync_ram_nport
// Synchronous RAM with one lane-masked write port and NUM_RD_P registered
// read ports (1-cycle latency), selectable read-during-write policy and an
// optional zeroing sweep after every reset.
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset (outputs only; array is never reset)
//   ram    : slave side of sync_ram_nport_if
//            data_i/wr_addr_i/wr_en_i/wr_mask_i : write port
//            rd_addr_i/rd_en_i                  : packed read requests
//            data_o/valid_o                     : packed registered read data
//            busy_o                             : clear sweep running
// filename_p names an init image for the platform memory-init flow; it may not
// be combined with the clear sweep, which would overwrite it.
// -----------------------------------------------------------------------------
module sync_ram_nport
    import sync_ram_pkg::*;
#(
    parameter int unsigned WIDTH_P          = 32,
    parameter int unsigned DEPTH_P          = 128,
    parameter int unsigned NUM_RD_P         = 2,
    parameter int unsigned LANE_W_P         = 8,
    parameter rdw_mode_e   RDW_MODE_P       = RDW_READ_FIRST,
    parameter int unsigned CLEAR_ON_RESET_P = 1,
    parameter string       filename_p       = ""
) (
    input logic             clk_i,
    input logic             rstn_i,
    sync_ram_nport_if.slave ram
);

    localparam int unsigned   ADDR_W  = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int unsigned   ADDR_WX = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = ADDR_WX'(DEPTH_P);

    if (LANE_W_P == 0 || (WIDTH_P % LANE_W_P) != 0) begin : g_bad_lane
        $error("sync_ram_nport: WIDTH_P must be a non-zero multiple of LANE_W_P");
    end
    if (NUM_RD_P < 1 || NUM_RD_P > 8) begin : g_bad_nrd
        $error("sync_ram_nport: NUM_RD_P must be in 1..8");
    end
    if (WIDTH_P > MERGE_W_MAX) begin : g_bad_width
        $error("sync_ram_nport: WIDTH_P exceeds lane_merge capacity");
    end
    if (filename_p != "" && CLEAR_ON_RESET_P != 0) begin : g_bad_init
        $error("sync_ram_nport: init file and clear-on-reset are exclusive");
    end

    logic [WIDTH_P-1:0] mem_r [DEPTH_P];

    logic                busy_s;
    logic                clr_we_s;
    logic [ADDR_W-1:0]   clr_addr_s;

    logic                wr_addr_ok_s;
    logic                user_we_s;
    logic [WIDTH_P-1:0]  old_word_s;
    logic [WIDTH_P-1:0]  merged_s;
    logic                arr_we_s;
    logic [ADDR_W-1:0]   arr_addr_s;
    logic [WIDTH_P-1:0]  arr_data_s;

    logic [NUM_RD_P-1:0][ADDR_W-1:0]  rd_addr_s;
    logic [NUM_RD_P-1:0][WIDTH_P-1:0] rd_word_s;
    logic [NUM_RD_P-1:0][WIDTH_P-1:0] rd_data_r;
    logic [NUM_RD_P-1:0]              rd_valid_r;

    ram_clear_seq #(
        .DEPTH_P    (DEPTH_P),
        .CLEAR_EN_P (CLEAR_ON_RESET_P),
        .ADDR_W_P   (ADDR_W)
    ) u_clear_seq (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Write path: merge the masked lanes into the old word, and let the sweep
    // own the array port while busy
    always_comb begin
        wr_addr_ok_s = ({1'b0, ram.wr_addr_i} < DEPTH_L);
        if (wr_addr_ok_s) begin
            old_word_s = mem_r[ram.wr_addr_i];
        end else begin
            old_word_s = '0;
        end
        merged_s  = WIDTH_P'(lane_merge(MERGE_W_MAX'(old_word_s),
                                        MERGE_W_MAX'(ram.data_i),
                                        MERGE_W_MAX'(ram.wr_mask_i),
                                        LANE_W_P));
        user_we_s = ~busy_s & ram.wr_en_i & wr_addr_ok_s & (ram.wr_mask_i != '0);
        if (busy_s) begin
            arr_we_s   = clr_we_s;
            arr_addr_s = clr_addr_s;
            arr_data_s = '0;
        end else begin
            arr_we_s   = user_we_s;
            arr_addr_s = ram.wr_addr_i;
            arr_data_s = merged_s;
        end
    end

    // Array write port (no reset: contents are zeroed only by the sweep)
    always_ff @(posedge clk_i) begin
        if (arr_we_s) begin
            mem_r[arr_addr_s] <= arr_data_s;
        end
    end

    // Per-port read word: out-of-range reads give zero; in write-first mode a
    // same-cycle write to the same address is forwarded as the merged word
    always_comb begin
        rd_addr_s = ram.rd_addr_i;
        rd_word_s = '0;
        for (int k = 0; k < NUM_RD_P; k++) begin
            if (RDW_MODE_P == RDW_WRITE_FIRST && user_we_s &&
                rd_addr_s[k] == ram.wr_addr_i) begin
                rd_word_s[k] = merged_s;
            end else if ({1'b0, rd_addr_s[k]} < DEPTH_L) begin
                rd_word_s[k] = mem_r[rd_addr_s[k]];
            end else begin
                rd_word_s[k] = '0;
            end
        end
    end

    // Registered read data and valid flags; data holds when a port is idle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data_r  <= '0;
            rd_valid_r <= '0;
        end else if (busy_s) begin
            rd_data_r  <= '0;
            rd_valid_r <= '0;
        end else begin
            rd_valid_r <= ram.rd_en_i;
            for (int k = 0; k < NUM_RD_P; k++) begin
                if (ram.rd_en_i[k]) begin
                    rd_data_r[k] <= rd_word_s[k];
                end
            end
        end
    end

    assign ram.data_o  = rd_data_r;
    assign ram.valid_o = rd_valid_r;
    assign ram.busy_o  = busy_s;

endmodule

// File: tb/tb_sync_ram_nport.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_nport
// Directed bench. Three RAM instances share one stimulus:
//   dut_a : DEPTH 128, 3 read ports, read-first
//   dut_b : DEPTH 128, 3 read ports, write-first
//   dut_c : DEPTH 100, 3 read ports, read-first
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sync_ram_nport;
    import sync_ram_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] data_v;
    logic [6:0]  wr_addr_v;
    logic        wr_en_v;
    logic [3:0]  wr_mask_v;
    logic [20:0] rd_addr_v;
    logic [2:0]  rd_en_v;

    int check_cnt = 0;
    int error_cnt = 0;

    sync_ram_nport_if #(.WIDTH_P(32), .DEPTH_P(128), .NUM_RD_P(3), .LANE_W_P(8)) bus_a ();
    sync_ram_nport_if #(.WIDTH_P(32), .DEPTH_P(128), .NUM_RD_P(3), .LANE_W_P(8)) bus_b ();
    sync_ram_nport_if #(.WIDTH_P(32), .DEPTH_P(100), .NUM_RD_P(3), .LANE_W_P(8)) bus_c ();

    assign bus_a.data_i = data_v;    assign bus_a.wr_addr_i = wr_addr_v;
    assign bus_a.wr_en_i = wr_en_v;  assign bus_a.wr_mask_i = wr_mask_v;
    assign bus_a.rd_addr_i = rd_addr_v; assign bus_a.rd_en_i = rd_en_v;
    assign bus_b.data_i = data_v;    assign bus_b.wr_addr_i = wr_addr_v;
    assign bus_b.wr_en_i = wr_en_v;  assign bus_b.wr_mask_i = wr_mask_v;
    assign bus_b.rd_addr_i = rd_addr_v; assign bus_b.rd_en_i = rd_en_v;
    assign bus_c.data_i = data_v;    assign bus_c.wr_addr_i = wr_addr_v;
    assign bus_c.wr_en_i = wr_en_v;  assign bus_c.wr_mask_i = wr_mask_v;
    assign bus_c.rd_addr_i = rd_addr_v; assign bus_c.rd_en_i = rd_en_v;

    sync_ram_nport #(.WIDTH_P(32), .DEPTH_P(128), .NUM_RD_P(3), .LANE_W_P(8),
                     .RDW_MODE_P(RDW_READ_FIRST), .CLEAR_ON_RESET_P(1), .filename_p(""))
        dut_a (.clk_i(clk), .rstn_i(rstn), .ram(bus_a));
    sync_ram_nport #(.WIDTH_P(32), .DEPTH_P(128), .NUM_RD_P(3), .LANE_W_P(8),
                     .RDW_MODE_P(RDW_WRITE_FIRST), .CLEAR_ON_RESET_P(1), .filename_p(""))
        dut_b (.clk_i(clk), .rstn_i(rstn), .ram(bus_b));
    sync_ram_nport #(.WIDTH_P(32), .DEPTH_P(100), .NUM_RD_P(3), .LANE_W_P(8),
                     .RDW_MODE_P(RDW_READ_FIRST), .CLEAR_ON_RESET_P(1), .filename_p(""))
        dut_c (.clk_i(clk), .rstn_i(rstn), .ram(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        wr_en_v = 1'b0;
        rd_en_v = 3'b000;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_addr_v = a;
        data_v    = d;
        wr_mask_v = m;
        wr_en_v   = 1'b1;
        @(negedge clk);
        wr_en_v   = 1'b0;
    endtask

    task automatic do_read(input logic [20:0] addrs, input logic [2:0] en);
        rd_addr_v = addrs;
        rd_en_v   = en;
        @(negedge clk);
        rd_en_v   = 3'b000;
    endtask

    // Counts busy cycles per instance from reset release; injects a write and
    // reads at sweep cycle 20 and counts any output activity while busy.
    task automatic count_busy(output int ca, output int cb, output int cc, output int vbad);
        ca = 0; cb = 0; cc = 0; vbad = 0;
        for (int i = 0; i < 400; i++) begin
            if (!bus_a.busy_o && !bus_b.busy_o && !bus_c.busy_o) break;
            if (bus_a.busy_o) ca++;
            if (bus_b.busy_o) cb++;
            if (bus_c.busy_o) cc++;
            if (bus_a.busy_o && (bus_a.valid_o != 3'b000 || bus_a.data_o != 96'h0)) vbad++;
            if (bus_b.busy_o && (bus_b.valid_o != 3'b000 || bus_b.data_o != 96'h0)) vbad++;
            if (bus_c.busy_o && (bus_c.valid_o != 3'b000 || bus_c.data_o != 96'h0)) vbad++;
            if (i == 20) begin
                wr_addr_v = 7'd3;
                data_v    = 32'hCAFEF00D;
                wr_mask_v = 4'b1111;
                wr_en_v   = 1'b1;
                rd_addr_v = {7'd3, 7'd3, 7'd3};
                rd_en_v   = 3'b111;
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        int ca, cb, cc, vbad;
        rstn      = 1'b0;
        data_v    = 32'h0;
        wr_addr_v = 7'd0;
        wr_mask_v = 4'b0000;
        rd_addr_v = 21'd0;
        drive_idle();
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_data_a", bus_a.data_o, 96'h0);
        check_eq("rst_valid_a", bus_a.valid_o, 3'b000);
        check_eq("rst_busy_a", bus_a.busy_o, 1'b1);
        check_eq("rst_busy_c", bus_c.busy_o, 1'b1);

        // Sweep length after release
        rstn = 1'b1;
        count_busy(ca, cb, cc, vbad);
        check_eq("sweep_len_a", ca, 128);
        check_eq("sweep_len_b", cb, 128);
        check_eq("sweep_len_c", cc, 100);
        check_eq("busy_quiet", vbad, 0);

        // Cleared words read back as zero, valid one cycle later
        do_read({7'd127, 7'd77, 7'd0}, 3'b111);
        check_eq("clr_rd_data", bus_a.data_o, 96'h0);
        check_eq("clr_rd_valid", bus_a.valid_o, 3'b111);
        check_eq("ready_busy", bus_a.busy_o, 1'b0);
        do_read({7'd0, 7'd0, 7'd3}, 3'b001);
        check_eq("busy_wr_dropped", bus_a.data_o[31:0], 32'h0);

        // Masked write
        do_write(7'd5, 32'hAABBCCDD, 4'b1111);
        do_write(7'd5, 32'h11223344, 4'b0101);
        do_read({7'd0, 7'd0, 7'd5}, 3'b001);
        check_eq("mask_merge", bus_a.data_o[31:0], 32'hAA22CC44);

        // Read during write on addr 9, ports 0 and 1
        wr_addr_v = 7'd9; data_v = 32'hDEADBEEF; wr_mask_v = 4'b0011; wr_en_v = 1'b1;
        rd_addr_v = {7'd0, 7'd9, 7'd9}; rd_en_v = 3'b011;
        @(negedge clk);
        drive_idle();
        check_eq("rdw_rf_p0", bus_a.data_o[31:0], 32'h00000000);
        check_eq("rdw_rf_p1", bus_a.data_o[63:32], 32'h00000000);
        check_eq("rdw_wf_p0", bus_b.data_o[31:0], 32'h0000BEEF);
        check_eq("rdw_wf_p1", bus_b.data_o[63:32], 32'h0000BEEF);
        do_read({7'd0, 7'd0, 7'd9}, 3'b001);
        check_eq("rdw_after_a", bus_a.data_o[31:0], 32'h0000BEEF);
        check_eq("rdw_after_b", bus_b.data_o[31:0], 32'h0000BEEF);

        // Multi-port, then hold of an idle port
        do_write(7'd1, 32'h1, 4'b1111);
        do_write(7'd2, 32'h2, 4'b1111);
        do_read({7'd2, 7'd1, 7'd1}, 3'b111);
        check_eq("mp_data", bus_a.data_o, 96'h00000002_00000001_00000001);
        check_eq("mp_valid", bus_a.valid_o, 3'b111);
        do_read({7'd5, 7'd9, 7'd5}, 3'b101);
        check_eq("mp_hold_data", bus_a.data_o, 96'hAA22CC44_00000001_AA22CC44);
        check_eq("mp_hold_valid", bus_a.valid_o, 3'b101);

        // Depth 100: addr 100 out of range for dut_c only
        do_write(7'd100, 32'hFFFFFFFF, 4'b1111);
        do_read({7'd0, 7'd0, 7'd100}, 3'b001);
        check_eq("oor_rd_c", bus_c.data_o[31:0], 32'h0);
        check_eq("oor_valid_c", bus_c.valid_o, 3'b001);
        check_eq("inrange_100_a", bus_a.data_o[31:0], 32'hFFFFFFFF);
        do_write(7'd99, 32'h12345678, 4'b1111);
        do_write(7'd99, 32'h00000000, 4'b0000);
        do_read({7'd0, 7'd0, 7'd99}, 3'b001);
        check_eq("last_word_c", bus_c.data_o[31:0], 32'h12345678);

        // Asynchronous reset from READY with live outputs
        do_read({7'd0, 7'd0, 7'd5}, 3'b001);
        check_eq("pre_rst_data", bus_a.data_o[31:0], 32'hAA22CC44);
        #2 rstn = 1'b0;
        #1;
        check_eq("async_rst_data", bus_a.data_o, 96'h0);
        check_eq("async_rst_valid", bus_a.valid_o, 3'b000);
        check_eq("async_rst_busy", bus_a.busy_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Abort the sweep at cycle 40, then a full sweep must follow
        repeat (40) @(negedge clk);
        check_eq("mid_sweep_busy", bus_a.busy_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus_a.valid_o, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        count_busy(ca, cb, cc, vbad);
        check_eq("resweep_len_a", ca, 128);
        check_eq("resweep_len_c", cc, 100);
        check_eq("resweep_quiet", vbad, 0);
        do_read({7'd100, 7'd3, 7'd5}, 3'b111);
        check_eq("resweep_clear", bus_a.data_o, 96'h0);
        check_eq("resweep_valid", bus_a.valid_o, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
